// File: rtl/tpic_readback.sv
// tpic_readback: checks the TPIC chain's serial output against the image written one frame earlier.
// Latency: status, counters and frame_done appear one clk after the rck rise; rd_data is one clk after rd_addr.
// Backpressure: none; the serialiser free-runs. Optional `TPIC_RB_FIRST_ERR_EN builds the first-error index encoder.
module tpic_readback #(
  parameter int WIDTH = 300,
  parameter int IDXW  = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sclk,
  input  logic             rck,
  input  logic             miso,
  input  logic [WIDTH-1:0] data,
  input  logic             clear,
  input  logic [7:0]       rd_addr,
  output logic [7:0]       rd_data,
  output logic             frame_done,
  output logic             rb_valid,
  output logic             mismatch,
  output logic             len_err,
  output logic [7:0]       frame_cnt,
  output logic [7:0]       err_cnt,
  output logic [IDXW-1:0]  first_err_idx
);

  // bit_cnt must reach WIDTH+1, which may need one bit more than an index
  localparam int CW   = IDXW + 1;
  localparam int NB   = (WIDTH + 7) / 8;
  localparam int PADW = NB * 8;
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);

  // sclk_q / rck_q / miso_q are one-clk delayed copies of the inputs
  logic             sclk_q, sclk_d;
  logic             rck_q, rck_d;
  logic             miso_q, miso_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [WIDTH-1:0] exp_prev_q, exp_prev_d;
  logic             prev_ok_q, prev_ok_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             rb_valid_q, rb_valid_d;
  logic             mismatch_q, mismatch_d;
  logic             len_err_q, len_err_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [7:0]       rd_data_q, rd_data_d;

  logic             shift_rise;
  logic             frame_end;
  logic [WIDTH-1:0] cap_nx;
  logic [CW-1:0]    cnt_nx;
  logic             len_ok;
  logic             len_fail;
  logic             cmp_fail;
  logic [PADW-1:0]  snap_pad;

  // Edge detection and the post-shift view used by a same-cycle frame end
  always_comb begin
    sclk_d     = sclk;
    rck_d      = rck;
    miso_d     = miso;
    shift_rise = enable & sclk & ~sclk_q;
    frame_end  = enable & rck & ~rck_q;
    cap_nx     = shift_rise ? {cap_q[WIDTH-2:0], miso_q} : cap_q;
    cnt_nx     = (shift_rise && bit_cnt_q != CNT_MAX) ? bit_cnt_q + CW'(1) : bit_cnt_q;
    len_ok     = (cnt_nx == CNT_FULL);
    len_fail   = frame_end & ~len_ok;
    cmp_fail   = frame_end & len_ok & prev_ok_q & (cap_nx != exp_prev_q);
  end

`ifdef TPIC_RB_FIRST_ERR_EN
  logic [IDXW-1:0]  first_err_idx_q, first_err_idx_d;
  logic [IDXW-1:0]  err_enc;
  logic [WIDTH-1:0] diff;

  // Highest differing bit of the frame being compared
  always_comb begin
    diff    = cap_nx ^ exp_prev_q;
    err_enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (diff[i]) err_enc = IDXW'(i);
    end
  end

  // First-error index: cleared by clear, reloaded on every failing compare
  always_comb begin
    first_err_idx_d = first_err_idx_q;
    if (clear)    first_err_idx_d = '0;
    if (cmp_fail) first_err_idx_d = err_enc;
  end

  // First-error index register
  always_ff @(posedge clk) begin
    if (!reset_n) first_err_idx_q <= '0;
    else          first_err_idx_q <= first_err_idx_d;
  end

  assign first_err_idx = first_err_idx_q;
`else
  assign first_err_idx = '0;
`endif

  // Capture, frame bookkeeping, sticky flags and counters
  always_comb begin
    cap_d        = cap_q;
    snap_d       = snap_q;
    exp_prev_d   = exp_prev_q;
    prev_ok_d    = prev_ok_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;
    rb_valid_d   = rb_valid_q;
    mismatch_d   = mismatch_q;
    len_err_d    = len_err_q;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;

    if (!enable) begin
      // abort: drop the partial frame and the expected-image validity
      cap_d     = '0;
      bit_cnt_d = '0;
      prev_ok_d = 1'b0;
    end else begin
      cap_d     = cap_nx;
      bit_cnt_d = cnt_nx;
      if (frame_end) begin
        snap_d       = cap_nx;
        frame_cnt_d  = frame_cnt_q + 8'd1;
        frame_done_d = 1'b1;
        rb_valid_d   = len_ok & prev_ok_q;
        exp_prev_d   = data;
        prev_ok_d    = len_ok;
        bit_cnt_d    = '0;
      end
    end

    // clear first so that a coincident error leaves the flag set and err_cnt at 1
    if (clear) begin
      mismatch_d = 1'b0;
      len_err_d  = 1'b0;
      err_cnt_d  = '0;
    end
    if (len_fail) len_err_d = 1'b1;
    if (cmp_fail) begin
      mismatch_d = 1'b1;
      err_cnt_d  = (err_cnt_d == 8'hFF) ? 8'hFF : err_cnt_d + 8'd1;
    end
  end

  // Snapshot byte mux; padding bits and out-of-range addresses read zero
  always_comb begin
    snap_pad  = PADW'(snap_q);
    rd_data_d = '0;
    for (int b = 0; b < NB; b++) begin
      if (rd_addr == 8'(b)) rd_data_d = snap_pad[8*b +: 8];
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_q       <= 1'b0;
      rck_q        <= 1'b0;
      miso_q       <= 1'b0;
      cap_q        <= '0;
      snap_q       <= '0;
      exp_prev_q   <= '0;
      prev_ok_q    <= 1'b0;
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      rb_valid_q   <= 1'b0;
      mismatch_q   <= 1'b0;
      len_err_q    <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
      rd_data_q    <= '0;
    end else begin
      sclk_q       <= sclk_d;
      rck_q        <= rck_d;
      miso_q       <= miso_d;
      cap_q        <= cap_d;
      snap_q       <= snap_d;
      exp_prev_q   <= exp_prev_d;
      prev_ok_q    <= prev_ok_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_done_q <= frame_done_d;
      rb_valid_q   <= rb_valid_d;
      mismatch_q   <= mismatch_d;
      len_err_q    <= len_err_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign frame_done = frame_done_q;
  assign rb_valid   = rb_valid_q;
  assign mismatch   = mismatch_q;
  assign len_err    = len_err_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_tpic_readback.sv
// Directed bench for tpic_readback with a 16-bit TPIC chain model looping back into miso.
// Inputs change on the falling clk edge; outputs are checked on the falling edge.
// Each scenario task carries its own expected values.
module tb_tpic_readback;

  localparam int W  = 16;
  localparam int IW = 5;
`ifdef TPIC_RB_FIRST_ERR_EN
  localparam logic [IW-1:0] IDX9  = 5'd9;
  localparam logic [IW-1:0] IDX3  = 5'd3;
  localparam logic [IW-1:0] IDX12 = 5'd12;
`else
  localparam logic [IW-1:0] IDX9  = 5'd0;
  localparam logic [IW-1:0] IDX3  = 5'd0;
  localparam logic [IW-1:0] IDX12 = 5'd0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          sclk;
  logic          rck;
  logic          miso;
  logic [W-1:0]  data;
  logic          clear;
  logic [7:0]    rd_addr;
  logic [7:0]    rd_data;
  logic          frame_done;
  logic          rb_valid;
  logic          mismatch;
  logic          len_err;
  logic [7:0]    frame_cnt;
  logic [7:0]    err_cnt;
  logic [IW-1:0] first_err_idx;

  logic [W-1:0]  chain;
  int            n_checks = 0;
  int            n_fail   = 0;

  always #20 clk = ~clk;

  tpic_readback #(.WIDTH(W), .IDXW(IW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sclk(sclk), .rck(rck),
    .miso(miso), .data(data), .clear(clear), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_done(frame_done), .rb_valid(rb_valid), .mismatch(mismatch),
    .len_err(len_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx)
  );

  // Serialiser + chain model: n shift clocks MSB first; SO optionally inverted
  // for the bit that will land at capture index flip_idx
  task automatic shift_bits(input logic [W-1:0] v, input int n, input int flip_idx);
    data = v;
    miso = chain[W-1] ^ (flip_idx >= 0 && 0 == W-1-flip_idx);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) sclk = 1'b0;
      @(negedge clk) begin
        sclk  = 1'b1;
        chain = {chain[W-2:0], v[W-1-i]};
        miso  = chain[W-1] ^ (flip_idx >= 0 && i + 1 == W-1-flip_idx);
      end
    end
    @(negedge clk) sclk = 1'b0;
  endtask

  // Latch strobe; returns on the falling edge where the frame results are visible
  task automatic end_frame(input logic do_clear);
    @(negedge clk) begin rck = 1'b1; clear = do_clear; end
    @(negedge clk) begin rck = 1'b0; clear = 1'b0; end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; enable = 1'b1; sclk = 1'b0; rck = 1'b0; miso = 1'b0;
    data = '0; clear = 1'b0; rd_addr = 8'd0; chain = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %0h want 0", frame_done); end
    n_checks++; if (rb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rb_valid got %0h want 0", rb_valid); end
    n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_mismatch got %0h want 0", mismatch); end
    n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL reset_len_err got %0h want 0", len_err); end
    n_checks++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_frame_cnt got %0h want 0", frame_cnt); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0h want 0", err_cnt); end
    n_checks++; if (first_err_idx !== '0) begin n_fail++; $display("FAIL reset_first_err_idx got %0h want 0", first_err_idx); end
    n_checks++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL reset_rd_data got %0h want 0", rd_data); end
  endtask

  task automatic test_good_frames;
    logic exp_v [3] = '{1'b0, 1'b1, 1'b1};
    for (int f = 0; f < 3; f++) begin
      shift_bits(16'hA5C3, W, -1);
      end_frame(1'b0);
      n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL good_frame_done[%0d] got %0h want 1", f, frame_done); end
      n_checks++; if (rb_valid !== exp_v[f]) begin n_fail++; $display("FAIL good_rb_valid[%0d] got %0h want %0h", f, rb_valid, exp_v[f]); end
    end
    @(negedge clk);
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL good_frame_done_pulse got %0h want 0", frame_done); end
    n_checks++; if (frame_cnt !== 8'd3) begin n_fail++; $display("FAIL good_frame_cnt got %0d want 3", frame_cnt); end
    n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL good_mismatch got %0h want 0", mismatch); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL good_err_cnt got %0d want 0", err_cnt); end
  endtask

  task automatic test_mismatch;
    shift_bits(16'h1234, W, -1);
    end_frame(1'b0);
    n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL mm_first_mismatch got %0h want 0", mismatch); end
    shift_bits(16'hFFFF, W, 9);
    end_frame(1'b0);
    n_checks++; if (rb_valid !== 1'b1) begin n_fail++; $display("FAIL mm_rb_valid got %0h want 1", rb_valid); end
    n_checks++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL mm_mismatch got %0h want 1", mismatch); end
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL mm_err_cnt got %0d want 1", err_cnt); end
    n_checks++; if (first_err_idx !== IDX9) begin n_fail++; $display("FAIL mm_first_err_idx got %0d want %0d", first_err_idx, IDX9); end
    n_checks++; if (frame_cnt !== 8'd5) begin n_fail++; $display("FAIL mm_frame_cnt got %0d want 5", frame_cnt); end
  endtask

  task automatic test_len_err;
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL clr_mismatch got %0h want 0", mismatch); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_err_cnt got %0d want 0", err_cnt); end
    n_checks++; if (first_err_idx !== '0) begin n_fail++; $display("FAIL clr_first_err_idx got %0d want 0", first_err_idx); end
    shift_bits(16'h0F0F, W-1, -1);
    end_frame(1'b0);
    n_checks++; if (len_err !== 1'b1) begin n_fail++; $display("FAIL len_len_err got %0h want 1", len_err); end
    n_checks++; if (rb_valid !== 1'b0) begin n_fail++; $display("FAIL len_rb_valid got %0h want 0", rb_valid); end
    shift_bits(16'h5555, W, -1);
    end_frame(1'b0);
    n_checks++; if (rb_valid !== 1'b0) begin n_fail++; $display("FAIL len_next_rb_valid got %0h want 0", rb_valid); end
    n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL len_next_mismatch got %0h want 0", mismatch); end
    n_checks++; if (frame_cnt !== 8'd7) begin n_fail++; $display("FAIL len_frame_cnt got %0d want 7", frame_cnt); end
  endtask

  task automatic test_readback;
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL rd_clr_len_err got %0h want 0", len_err); end
    shift_bits(16'hBEEF, W, -1);
    end_frame(1'b0);
    shift_bits(16'hBEEF, W, -1);
    end_frame(1'b0);
    n_checks++; if (rb_valid !== 1'b1) begin n_fail++; $display("FAIL rd_rb_valid got %0h want 1", rb_valid); end
    n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL rd_mismatch got %0h want 0", mismatch); end
    rd_addr = 8'd0;
    @(negedge clk);
    n_checks++; if (rd_data !== 8'hEF) begin n_fail++; $display("FAIL rd_byte0 got %0h want ef", rd_data); end
    rd_addr = 8'd1;
    #1;
    n_checks++; if (rd_data !== 8'hEF) begin n_fail++; $display("FAIL rd_byte1_latency got %0h want ef", rd_data); end
    @(negedge clk);
    n_checks++; if (rd_data !== 8'hBE) begin n_fail++; $display("FAIL rd_byte1 got %0h want be", rd_data); end
    rd_addr = 8'd2;
    @(negedge clk);
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rd_byte2 got %0h want 00", rd_data); end
    rd_addr = 8'd255;
    @(negedge clk);
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rd_byte255 got %0h want 00", rd_data); end
    rd_addr = 8'd0;
  endtask

  task automatic test_enable_abort;
    shift_bits(16'h3C3C, 7, -1);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    shift_bits(16'h1111, W, -1);
    end_frame(1'b0);
    n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL ab_len_err_a got %0h want 0", len_err); end
    n_checks++; if (rb_valid !== 1'b0) begin n_fail++; $display("FAIL ab_rb_valid_a got %0h want 0", rb_valid); end
    shift_bits(16'h2222, W, -1);
    end_frame(1'b0);
    n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL ab_len_err_b got %0h want 0", len_err); end
    n_checks++; if (rb_valid !== 1'b1) begin n_fail++; $display("FAIL ab_rb_valid_b got %0h want 1", rb_valid); end
    n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL ab_mismatch got %0h want 0", mismatch); end
    n_checks++; if (frame_cnt !== 8'd11) begin n_fail++; $display("FAIL ab_frame_cnt got %0d want 11", frame_cnt); end
  endtask

  task automatic test_clear_collision;
    shift_bits(16'h0101, W, -1);
    end_frame(1'b0);
    shift_bits(16'h0202, W, 3);
    end_frame(1'b0);
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL cc_err_cnt_pre got %0d want 1", err_cnt); end
    n_checks++; if (first_err_idx !== IDX3) begin n_fail++; $display("FAIL cc_first_err_idx_pre got %0d want %0d", first_err_idx, IDX3); end
    shift_bits(16'h0303, W, 12);
    end_frame(1'b1);
    n_checks++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL cc_mismatch got %0h want 1", mismatch); end
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL cc_err_cnt got %0d want 1", err_cnt); end
    n_checks++; if (first_err_idx !== IDX12) begin n_fail++; $display("FAIL cc_first_err_idx got %0d want %0d", first_err_idx, IDX12); end
    n_checks++; if (frame_cnt !== 8'd14) begin n_fail++; $display("FAIL cc_frame_cnt got %0d want 14", frame_cnt); end
    reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL rst_mismatch got %0h want 0", mismatch); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_err_cnt got %0d want 0", err_cnt); end
    n_checks++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_frame_cnt got %0d want 0", frame_cnt); end
    n_checks++; if (rb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rb_valid got %0h want 0", rb_valid); end
    n_checks++; if (first_err_idx !== '0) begin n_fail++; $display("FAIL rst_first_err_idx got %0d want 0", first_err_idx); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done got %0h want 0", frame_done); end
    n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL rst_len_err got %0h want 0", len_err); end
    n_checks++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL rst_rd_data got %0h want 0", rd_data); end
  endtask

  initial begin
    test_reset();
    test_good_frames();
    test_mismatch();
    test_len_err();
    test_readback();
    test_enable_abort();
    test_clear_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
